// File: rtl/fifo_pack_reader.sv
// Show-ahead FIFO consumer: packs PACK_RATIO words per wide beat on a valid/ready
// stream, marks burst ends with m_last, and emits zero-padded partial beats on flush.
module fifo_pack_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int PACK_RATIO  = 4,
  parameter int BURST_BEATS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             flush_done
);

  localparam int CW = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int AW = DATA_WIDTH * (PACK_RATIO - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(PACK_RATIO - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                                 state_r;
  logic [CW-1:0]                          word_cnt_r;
  logic [BW-1:0]                          beat_cnt_r;
  logic [PACK_RATIO-2:0][DATA_WIDTH-1:0]  acc_r;
  logic                                   rd_en_s;
  logic                                   final_stall_s;
  logic [PACK_RATIO-1:0]                  partial_keep_s;

  // Pop decision and keep mask for a partial beat.
  always_comb begin
    final_stall_s  = (word_cnt_r == LAST_WORD) & m_valid & ~m_ready;
    rd_en_s        = (state_r == FILL) & ~fifo_empty & ~final_stall_s & ~rst;
    partial_keep_s = {PACK_RATIO{1'b0}};
    for (int i = 0; i < PACK_RATIO; i++) begin
      partial_keep_s[i] = (i < int'(word_cnt_r));
    end
  end

  assign fifo_rd_en = rd_en_s;

  // Accumulator, counters, FILL/FLUSH state and the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FILL;
      word_cnt_r <= {CW{1'b0}};
      beat_cnt_r <= {BW{1'b0}};
      acc_r      <= {AW{1'b0}};
      m_data     <= {(DATA_WIDTH*PACK_RATIO){1'b0}};
      m_keep     <= {PACK_RATIO{1'b0}};
      m_last     <= 1'b0;
      m_valid    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (state_r)
        FILL: begin
          if (rd_en_s) begin
            if (word_cnt_r == LAST_WORD) begin
              m_data     <= {fifo_dout, acc_r};
              m_keep     <= {PACK_RATIO{1'b1}};
              m_last     <= flush | (beat_cnt_r == LAST_BEAT);
              m_valid    <= 1'b1;
              beat_cnt_r <= (flush || (beat_cnt_r == LAST_BEAT)) ? {BW{1'b0}}
                                                                 : beat_cnt_r + BW'(1);
              word_cnt_r <= {CW{1'b0}};
              acc_r      <= {AW{1'b0}};
            end else begin
              acc_r[word_cnt_r] <= fifo_dout;
              word_cnt_r        <= word_cnt_r + CW'(1);
            end
          end
          if (flush) begin
            state_r <= FLUSH;
          end
        end
        FLUSH: begin
          if (word_cnt_r == {CW{1'b0}}) begin
            flush_done <= 1'b1;
            state_r    <= FILL;
          end else if (!m_valid || m_ready) begin
            // Unused slots are already zero because the accumulator clears per beat.
            m_data     <= {{DATA_WIDTH{1'b0}}, acc_r};
            m_keep     <= partial_keep_s;
            m_last     <= 1'b1;
            m_valid    <= 1'b1;
            beat_cnt_r <= {BW{1'b0}};
            word_cnt_r <= {CW{1'b0}};
            acc_r      <= {AW{1'b0}};
            flush_done <= 1'b1;
            state_r    <= FILL;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Randomized and directed bench for fifo_pack_reader against a queue-based beat model.
module tb_fifo_pack_reader;
  localparam int DW = 16;
  localparam int PR = 4;
  localparam int BB = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fifo_empty = 1'b1;
  logic [DW-1:0]   fifo_dout = '0;
  logic            fifo_rd_en;
  logic            flush = 1'b0;
  logic [DW*PR-1:0] m_data;
  logic [PR-1:0]   m_keep;
  logic            m_last;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            flush_done;

  fifo_pack_reader #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .BURST_BEATS(BB)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*PR-1:0] d;
    logic [PR-1:0]    k;
    logic             l;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  // Model: external FIFO contents, words packed so far, pending output beat.
  logic [DW-1:0]    src_q[$];
  logic [DW-1:0]    acc_q[$];
  beat_t            mb_q[$];
  bit               in_flush = 0;
  int               burst_pos = 0;
  bit               o_valid = 0;
  bit               o_last = 0;
  bit               o_fd = 0;
  logic [DW*PR-1:0] o_data = '0;
  logic [PR-1:0]    o_keep = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    acc_q.delete();
    in_flush  = 0;
    burst_pos = 0;
    o_valid   = 0;
    o_last    = 0;
    o_fd      = 0;
    o_data    = '0;
    o_keep    = '0;
  endtask

  task automatic emit(input bit last);
    beat_t b;
    o_data = '0;
    foreach (acc_q[i]) o_data[i*DW +: DW] = acc_q[i];
    o_keep  = PR'((1 << acc_q.size()) - 1);
    o_last  = last;
    o_valid = 1;
    b.d = o_data; b.k = o_keep; b.l = o_last;
    mb_q.push_back(b);
    acc_q.delete();
  endtask

  task automatic model_edge(input bit rd);
    bit hs;
    bit loaded;
    bit l;
    hs     = o_valid && m_ready;
    loaded = 0;
    o_fd   = 0;
    if (!in_flush) begin
      if (rd) begin
        acc_q.push_back(src_q.pop_front());
        if (acc_q.size() == PR) begin
          l = flush || (burst_pos == BB - 1);
          emit(l);
          burst_pos = l ? 0 : burst_pos + 1;
          loaded = 1;
        end
      end
      if (flush) in_flush = 1;
    end else if (acc_q.size() == 0) begin
      o_fd = 1;
      in_flush = 0;
    end else if (!o_valid || m_ready) begin
      emit(1);
      burst_pos = 0;
      o_fd = 1;
      in_flush = 0;
      loaded = 1;
    end
    if (!loaded && hs) o_valid = 0;
  endtask

  // One clock: drive FIFO view, check pop strobe, advance model, check outputs.
  task automatic tick();
    bit exp_rd;
    fifo_empty = (src_q.size() == 0);
    fifo_dout  = fifo_empty ? DW'($urandom) : src_q[0];
    #1;
    exp_rd = !in_flush && !fifo_empty && !((acc_q.size() == PR - 1) && o_valid && !m_ready);
    check("rd_en", fifo_rd_en, exp_rd);
    if (fifo_rd_en) rd_cnt++;
    @(posedge clk);
    model_edge(exp_rd);
    @(negedge clk);
    check("m_valid", m_valid, o_valid);
    check("flush_done", flush_done, o_fd);
    if (o_valid) begin
      check("m_data", m_data, o_data);
      check("m_keep", m_keep, o_keep);
      check("m_last", m_last, o_last);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_keep"}, m_keep, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_fd"}, flush_done, 0);
    check({tag, "_rd"}, fifo_rd_en, 0);
  endtask

  // Asynchronous reset applied between clock edges; called at a negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("rst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_lasts(input string name, input int n);
    check({name, "_nbeats"}, mb_q.size(), n);
    foreach (mb_q[i]) check({name, "_last"}, mb_q[i].l, (i == BB - 1));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_zero("init");
    rst = 1'b0;

    // Two full beats from words 1..8.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    rd_cnt = 0;
    mb_q.delete();
    repeat (12) tick();
    check("t1_rd_cnt", rd_cnt, 8);
    check("t1_nbeats", mb_q.size(), 2);
    if (mb_q.size() >= 2) begin
      check("t1_b0", mb_q[0].d, 64'h0004_0003_0002_0001);
      check("t1_b1", mb_q[1].d, 64'h0008_0007_0006_0005);
      check("t1_keep", mb_q[0].k, 4'hF);
      check("t1_last", mb_q[1].l, 1'b0);
    end

    // Burst boundary over 36 words.
    do_reset();
    src_q.delete();
    for (int i = 1; i <= 36; i++) src_q.push_back(DW'(i));
    mb_q.delete();
    repeat (45) tick();
    check_lasts("t2", 9);

    // Backpressure with 7 words available.
    do_reset();
    src_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 7; i++) src_q.push_back(DW'(16'h0100 + i));
    rd_cnt = 0;
    mb_q.delete();
    repeat (15) tick();
    check("t3_rd_cnt", rd_cnt, 7);
    check("t3_valid", m_valid, 1'b1);
    check("t3_hold", m_data, 64'h0104_0103_0102_0101);
    src_q.push_back(16'h0108);
    m_ready = 1'b1;
    repeat (3) tick();
    check("t3_nbeats", mb_q.size(), 2);
    if (mb_q.size() >= 2) check("t3_b1", mb_q[1].d, 64'h0108_0107_0106_0105);

    // Partial flush of three words, then a full burst.
    do_reset();
    src_q.delete();
    src_q.push_back(16'h000A); src_q.push_back(16'h000B); src_q.push_back(16'h000C);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t4_valid", m_valid, 1'b1);
    check("t4_fd", flush_done, 1'b1);
    check("t4_data", m_data, 64'h0000_000C_000B_000A);
    check("t4_keep", m_keep, 4'b0111);
    check("t4_last", m_last, 1'b1);
    mb_q.delete();
    for (int i = 1; i <= 32; i++) src_q.push_back(DW'(16'h0200 + i));
    repeat (40) tick();
    check_lasts("t4b", 8);

    // Empty flush: no beat, flush_done one cycle after entering FLUSH.
    do_reset();
    src_q.delete();
    mb_q.delete();
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_fd0", flush_done, 1'b0);
    tick();
    check("t5_fd1", flush_done, 1'b1);
    check("t5_valid", m_valid, 1'b0);
    tick();
    check("t5_fd2", flush_done, 1'b0);
    check("t5_nbeats", mb_q.size(), 0);

    // Reset mid-operation discards the partial accumulation.
    do_reset();
    src_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) src_q.push_back(DW'(16'h0300 + i));
    repeat (8) tick();
    check("t6_valid", m_valid, 1'b1);
    do_reset();
    src_q.delete();
    for (int i = 1; i <= 4; i++) src_q.push_back(DW'(16'h0010 + i));
    m_ready = 1'b1;
    mb_q.delete();
    repeat (6) tick();
    check("t6_nbeats", mb_q.size(), 1);
    if (mb_q.size() >= 1) check("t6_b0", mb_q[0].d, 64'h0014_0013_0012_0011);

    // Randomized traffic, backpressure, flushes and occasional resets.
    do_reset();
    src_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 3 != 0) && (src_q.size() < 16)) src_q.push_back(DW'($urandom));
      m_ready = ($urandom % 4 != 0);
      flush   = ($urandom % 40 == 0);
      if ($urandom % 500 == 0) do_reset();
      else tick();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
